// File: rtl/btb_update_ctrl.sv
// rtl/btb_update_ctrl.sv - BTB update buffer with init/flush sweep controller
//
// Purpose:
//   Buffers up to two branch-update requests per cycle in a small FIFO and
//   drains one entry per cycle into the BTB write port. After reset, and on
//   every invalidate-all request, it sweeps the whole BTB index space with
//   clear writes before accepting updates again.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   upd_valid_i[1:0]  per-slot update request (slot 0 older than slot 1)
//   upd_pc_i          per-slot branch PC[31:2]
//   upd_bta_i         per-slot branch target[31:2]
//   upd_type_i        per-slot branch type
//   upd_ready_o       both slots are accepted this cycle when high
//   inv_all_i         one-cycle request to invalidate the whole BTB
//   btb_we_o          BTB write enable
//   btb_wpc_o         BTB write PC[31:2]
//   btb_bta_o         BTB write target
//   btb_type_o        BTB write branch type
//   btb_clr_o         current write stores an invalid entry
//   busy_o            sweep in progress
module btb_update_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       upd_valid_i,
  input  logic [1:0][29:0] upd_pc_i,
  input  logic [1:0][29:0] upd_bta_i,
  input  logic [1:0][1:0]  upd_type_i,
  output logic             upd_ready_o,
  input  logic             inv_all_i,
  output logic             btb_we_o,
  output logic [29:0]      btb_wpc_o,
  output logic [29:0]      btb_bta_o,
  output logic [1:0]       btb_type_o,
  output logic             btb_clr_o,
  output logic             busy_o
);

  localparam int SW = ADDR_WIDTH + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   sc_q, sc_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic [29:0]     pc_mem_q   [FIFO_DEPTH];
  logic [29:0]     bta_mem_q  [FIFO_DEPTH];
  logic [1:0]      type_mem_q [FIFO_DEPTH];

  logic            sweep;
  logic            can_accept;
  logic            accept;
  logic            push0;
  logic            push1;
  logic            pop;
  logic [CW-1:0]   free_cnt;
  logic [PW-1:0]   wr_idx1;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT, S_FLUSH: begin
        // A new invalidate restarts the sweep even on its last cycle.
        if (inv_all_i) begin
          state_d = S_FLUSH;
        end else if (sc_q == {SW{1'b1}}) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (inv_all_i) begin
          state_d = S_FLUSH;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath control
  // ---------------------------------------------------------------------------
  always_comb begin
    sweep      = (state_q != S_RUN);
    free_cnt   = CW'(FIFO_DEPTH) - count_q;
    // Readiness depends only on registered occupancy so the requester never
    // sees a combinational path from its own valids.
    can_accept = (state_q == S_RUN) && (free_cnt >= CW'(2));
    accept     = can_accept && !inv_all_i;
    push0      = accept && upd_valid_i[0];
    push1      = accept && upd_valid_i[1];
    pop        = (state_q == S_RUN) && (count_q != '0);
    // Slot 1 lands behind slot 0 only when slot 0 actually took an entry.
    wr_idx1    = wr_ptr_q + PW'(push0);

    // The sweep counter wraps to zero on its last cycle, so it is already
    // zero whenever RUN is entered.
    if (inv_all_i) begin
      sc_d = '0;
    end else if (sweep) begin
      sc_d = sc_q + SW'(1);
    end else begin
      sc_d = sc_q;
    end

    if ((state_q == S_RUN) && inv_all_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PW'(push0) + PW'(push1);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      count_d  = count_q + CW'(push0) + CW'(push1) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sc_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      sc_q     <= sc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push0) begin
      pc_mem_q[wr_ptr_q]   <= upd_pc_i[0];
      bta_mem_q[wr_ptr_q]  <= upd_bta_i[0];
      type_mem_q[wr_ptr_q] <= upd_type_i[0];
    end
    if (push1) begin
      pc_mem_q[wr_idx1]   <= upd_pc_i[1];
      bta_mem_q[wr_idx1]  <= upd_bta_i[1];
      type_mem_q[wr_idx1] <= upd_type_i[1];
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    upd_ready_o = 1'b0;
    btb_we_o    = 1'b0;
    btb_clr_o   = 1'b0;
    btb_wpc_o   = '0;
    btb_bta_o   = '0;
    btb_type_o  = '0;
    busy_o      = 1'b0;
    // Reset is synchronous for state, but outputs must already be quiet while
    // it is held, before the first clock edge has cleared the registers.
    if (!rst_n) begin
      busy_o = 1'b1;
    end else begin
      case (state_q)
        S_INIT, S_FLUSH: begin
          busy_o    = 1'b1;
          btb_we_o  = 1'b1;
          btb_clr_o = 1'b1;
          btb_wpc_o = 30'(sc_q);
        end
        S_RUN: begin
          upd_ready_o = can_accept;
          if (pop) begin
            btb_we_o   = 1'b1;
            btb_wpc_o  = pc_mem_q[rd_ptr_q];
            btb_bta_o  = bta_mem_q[rd_ptr_q];
            btb_type_o = type_mem_q[rd_ptr_q];
          end
        end
        default: busy_o = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_btb_update_ctrl.sv
// tb/tb_btb_update_ctrl.sv - self-checking bench for btb_update_ctrl
module tb_btb_update_ctrl;

  typedef struct packed {
    logic [29:0] pc;
    logic [29:0] bta;
    logic [1:0]  ty;
  } upd_t;

  logic             clk;
  logic             rst_n;
  logic [1:0]       upd_valid;
  logic [1:0][29:0] upd_pc;
  logic [1:0][29:0] upd_bta;
  logic [1:0][1:0]  upd_type;
  logic             upd_ready;
  logic             inv_all;
  logic             btb_we;
  logic [29:0]      btb_wpc;
  logic [29:0]      btb_bta;
  logic [1:0]       btb_type;
  logic             btb_clr;
  logic             busy;

  int   checks = 0;
  int   errors = 0;
  upd_t exp_q[$];
  upd_t mon_e;

  btb_update_ctrl #(.ADDR_WIDTH(4), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .upd_valid_i(upd_valid),
    .upd_pc_i   (upd_pc),
    .upd_bta_i  (upd_bta),
    .upd_type_i (upd_type),
    .upd_ready_o(upd_ready),
    .inv_all_i  (inv_all),
    .btb_we_o   (btb_we),
    .btb_wpc_o  (btb_wpc),
    .btb_bta_o  (btb_bta),
    .btb_type_o (btb_type),
    .btb_clr_o  (btb_clr),
    .busy_o     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard consumer: every non-clear write must match the oldest
  // accepted update.
  always @(negedge clk) begin
    if (rst_n && btb_we && !btb_clr) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: write pc=%h bta=%h type=%0d, none expected",
                 btb_wpc, btb_bta, btb_type);
      end else begin
        mon_e = exp_q.pop_front();
        if ({btb_wpc, btb_bta, btb_type} !== mon_e) begin
          errors++;
          $display("FAIL sb_write: got pc=%h bta=%h type=%0d, expected pc=%h bta=%h type=%0d",
                   btb_wpc, btb_bta, btb_type, mon_e.pc, mon_e.bta, mon_e.ty);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic upd_t mk(input logic [29:0] p, input logic [29:0] b);
    upd_t e;
    e.pc  = p;
    e.bta = b;
    e.ty  = p[5:4];
    return e;
  endfunction

  // Drive both slots; bench-side record of accepted entries follows the
  // ready value seen in the same cycle.
  task automatic drive(input logic [1:0] v, input logic [29:0] p0, input logic [29:0] p1,
                       input logic [29:0] b0, input logic [29:0] b1, input bit record);
    upd_valid   = v;
    upd_pc[0]   = p0;
    upd_pc[1]   = p1;
    upd_bta[0]  = b0;
    upd_bta[1]  = b1;
    upd_type[0] = p0[5:4];
    upd_type[1] = p1[5:4];
    if (record && upd_ready && !inv_all) begin
      if (v[0]) exp_q.push_back(mk(p0, b0));
      if (v[1]) exp_q.push_back(mk(p1, b1));
    end
  endtask

  task automatic idle();
    drive(2'b00, '0, '0, '0, '0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    inv_all = 1'b0;
    idle();
    repeat (3) tick();
    checks++;
    if (btb_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", btb_we); end
    checks++;
    if (btb_clr !== 1'b0) begin errors++; $display("FAIL reset_clr: got %b want 0", btb_clr); end
    checks++;
    if (upd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", upd_ready); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %b want 1", busy); end
    checks++;
    if (btb_wpc !== 30'h0) begin errors++; $display("FAIL reset_wpc: got %h want 0", btb_wpc); end
  endtask

  task automatic test_init_sweep();
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (!(btb_we === 1'b1 && btb_clr === 1'b1 && btb_wpc === 30'(i) && btb_bta === 30'h0 &&
            btb_type === 2'b0 && busy === 1'b1 && upd_ready === 1'b0)) begin
        errors++;
        $display("FAIL init_sweep[%0d]: we=%b clr=%b wpc=%h busy=%b rdy=%b want 1 1 %h 1 0",
                 i, btb_we, btb_clr, btb_wpc, busy, upd_ready, 30'(i));
      end
      tick();
    end
    checks++;
    if (!(busy === 1'b0 && upd_ready === 1'b1 && btb_we === 1'b0)) begin
      errors++;
      $display("FAIL init_exit: busy=%b rdy=%b we=%b want 0 1 0", busy, upd_ready, btb_we);
    end
  endtask

  task automatic test_pair();
    drive(2'b11, 30'h100, 30'h200, 30'h1111, 30'h2222, 1'b1);
    #1;
    checks++;
    if (btb_we !== 1'b0) begin errors++; $display("FAIL pair_no_bypass: we=%b want 0", btb_we); end
    tick();
    idle();
    checks++;
    if (!(btb_we === 1'b1 && btb_clr === 1'b0 && btb_wpc === 30'h100)) begin
      errors++;
      $display("FAIL pair_first: we=%b clr=%b wpc=%h want 1 0 100", btb_we, btb_clr, btb_wpc);
    end
    tick();
    checks++;
    if (!(btb_we === 1'b1 && btb_clr === 1'b0 && btb_wpc === 30'h200)) begin
      errors++;
      $display("FAIL pair_second: we=%b clr=%b wpc=%h want 1 0 200", btb_we, btb_clr, btb_wpc);
    end
    tick();
    checks++;
    if (!(btb_we === 1'b0 && btb_wpc === 30'h0 && exp_q.size() == 0)) begin
      errors++;
      $display("FAIL pair_drained: we=%b wpc=%h pending=%0d want 0 0 0", btb_we, btb_wpc, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int k;
    logic exp_rdy;
    k = 0;
    for (int c = 0; c < 4; c++) begin
      exp_rdy = (c != 2);
      checks++;
      if (upd_ready !== exp_rdy) begin
        errors++;
        $display("FAIL b2b_ready[%0d]: got %b want %b", c, upd_ready, exp_rdy);
      end
      drive(2'b11, 30'h300 + 30'(8 * k), 30'h304 + 30'(8 * k),
            30'h5000 + 30'(k), 30'h6000 + 30'(k), 1'b1);
      if (upd_ready) k++;
      tick();
    end
    idle();
    repeat (5) tick();
    checks++;
    if (k != 3 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_drain: accepted=%0d pending=%0d want 3 0", k, exp_q.size());
    end
  endtask

  task automatic test_slot1_only();
    checks++;
    if (upd_ready !== 1'b1) begin errors++; $display("FAIL slot1_ready: got %b want 1", upd_ready); end
    drive(2'b10, 30'h3ff, 30'h44, 30'h777, 30'h888, 1'b1);
    tick();
    idle();
    checks++;
    if (!(btb_we === 1'b1 && btb_clr === 1'b0 && btb_wpc === 30'h44 && btb_bta === 30'h888)) begin
      errors++;
      $display("FAIL slot1_write: we=%b wpc=%h bta=%h want 1 44 888", btb_we, btb_wpc, btb_bta);
    end
    tick();
    checks++;
    if (btb_we !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL slot1_single: we=%b pending=%0d want 0 0", btb_we, exp_q.size());
    end
  endtask

  task automatic test_same_pc();
    drive(2'b11, 30'h80, 30'h80, 30'hAAA, 30'hBBB, 1'b1);
    tick();
    idle();
    tick();
    checks++;
    if (!(btb_we === 1'b1 && btb_wpc === 30'h80 && btb_bta === 30'hBBB)) begin
      errors++;
      $display("FAIL same_pc_last: we=%b wpc=%h bta=%h want 1 80 bbb", btb_we, btb_wpc, btb_bta);
    end
    tick();
  endtask

  task automatic test_flush_pending();
    drive(2'b11, 30'h500, 30'h504, 30'h10, 30'h11, 1'b1);
    tick();
    drive(2'b11, 30'h508, 30'h50c, 30'h12, 30'h13, 1'b1);
    tick();
    checks++;
    if (upd_ready !== 1'b0) begin errors++; $display("FAIL flushp_ready: got %b want 0", upd_ready); end
    inv_all = 1'b1;
    drive(2'b11, 30'h510, 30'h514, 30'h14, 30'h15, 1'b1);
    #1;
    checks++;
    if (!(btb_we === 1'b1 && btb_clr === 1'b0 && btb_wpc === 30'h504)) begin
      errors++;
      $display("FAIL flushp_head: we=%b clr=%b wpc=%h want 1 0 504", btb_we, btb_clr, btb_wpc);
    end
    tick();
    inv_all = 1'b0;
    idle();
    checks++;
    if (exp_q.size() != 2) begin
      errors++;
      $display("FAIL flushp_discard: pending=%0d want 2", exp_q.size());
    end
    exp_q.delete();
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (!(btb_we === 1'b1 && btb_clr === 1'b1 && btb_wpc === 30'(i) && busy === 1'b1)) begin
        errors++;
        $display("FAIL flushp_sweep[%0d]: we=%b clr=%b wpc=%h busy=%b", i, btb_we, btb_clr, btb_wpc, busy);
      end
      tick();
    end
    checks++;
    if (!(busy === 1'b0 && upd_ready === 1'b1)) begin
      errors++;
      $display("FAIL flushp_exit: busy=%b rdy=%b want 0 1", busy, upd_ready);
    end
    repeat (3) tick();
  endtask

  task automatic test_flush_restart();
    inv_all = 1'b1;
    drive(2'b11, 30'h600, 30'h604, 30'h20, 30'h21, 1'b1);
    tick();
    inv_all = 1'b0;
    idle();
    for (int i = 0; i <= 20; i++) begin
      checks++;
      if (!(btb_we === 1'b1 && btb_clr === 1'b1 && btb_wpc === 30'(i))) begin
        errors++;
        $display("FAIL restart_pre[%0d]: we=%b clr=%b wpc=%h", i, btb_we, btb_clr, btb_wpc);
      end
      if (i == 20) inv_all = 1'b1;
      tick();
    end
    inv_all = 1'b0;
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (!(btb_we === 1'b1 && btb_clr === 1'b1 && btb_wpc === 30'(i) && busy === 1'b1)) begin
        errors++;
        $display("FAIL restart_sweep[%0d]: we=%b clr=%b wpc=%h busy=%b", i, btb_we, btb_clr, btb_wpc, busy);
      end
      tick();
    end
    checks++;
    if (!(busy === 1'b0 && upd_ready === 1'b1)) begin
      errors++;
      $display("FAIL restart_exit: busy=%b rdy=%b want 0 1", busy, upd_ready);
    end
    repeat (3) tick();
  endtask

  task automatic test_reset_mid();
    drive(2'b11, 30'h700, 30'h704, 30'h30, 30'h31, 1'b1);
    tick();
    idle();
    rst_n = 1'b0;
    #1;
    checks++;
    if (!(btb_we === 1'b0 && busy === 1'b1 && upd_ready === 1'b0)) begin
      errors++;
      $display("FAIL midreset_out: we=%b busy=%b rdy=%b want 0 1 0", btb_we, busy, upd_ready);
    end
    tick();
    exp_q.delete();
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 32; i++) begin
      checks++;
      if (!(btb_we === 1'b1 && btb_clr === 1'b1 && btb_wpc === 30'(i))) begin
        errors++;
        $display("FAIL midreset_sweep[%0d]: we=%b clr=%b wpc=%h", i, btb_we, btb_clr, btb_wpc);
      end
      tick();
    end
    checks++;
    if (!(busy === 1'b0 && upd_ready === 1'b1 && btb_we === 1'b0)) begin
      errors++;
      $display("FAIL midreset_exit: busy=%b rdy=%b we=%b want 0 1 0", busy, upd_ready, btb_we);
    end
    repeat (3) tick();
  endtask

  initial begin
    test_reset();
    test_init_sweep();
    test_pair();
    test_back_to_back();
    test_slot1_only();
    test_same_pc();
    test_flush_pending();
    test_flush_restart();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
